// File: rtl/adder_serial_nbit.sv
// Digit-serial N-bit adder/subtractor, W bits per clock.
// start/done handshake; reports carry-out and signed overflow.
module adder_serial_nbit #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         carryout,
  output logic         overflow
);

  localparam int WS = (W < 1) ? 1 : W;
  localparam int D  = N / WS;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  generate
    if (N < 1 || W < 1 || W > N || (N % WS) != 0) begin : g_bad
      $error("adder_serial_nbit: need 1 <= W <= N and N %% W == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  opa;
  logic [N-1:0]  opb;
  logic [N-1:0]  acc;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [W-1:0]  da;
  logic [W-1:0]  db;
  logic [W:0]    dsum;
  logic [N-1:0]  acc_nxt;
  logic          last;

  // Digits enter at the top of acc and shift down, so after D
  // steps digit 0 sits in the low bits.
  always_comb begin
    da      = W'(opa >> (int'(cnt) * W));
    db      = W'(opb >> (int'(cnt) * W));
    dsum    = {1'b0, da} + {1'b0, db} + {{W{1'b0}}, carry};
    acc_nxt = (acc >> W) | (N'(dsum[W-1:0]) << (N - W));
    last    = (cnt == CW'(D - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          carry <= dsum[W];
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum      <= acc_nxt;
            carryout <= dsum[W];
            overflow <= (opa[N-1] == opb[N-1]) &&
                        (acc_nxt[N-1] != opa[N-1]);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Scoreboard bench for adder_serial_nbit: directed N=8/W=2 vectors
// plus an exhaustive N=4 sweep at W=1,2,4.
module tb_adder_serial_nbit;

  localparam int D = 4;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carryout;
  logic       overflow;

  int   errors;
  int   checks;
  bit   sweep_go;
  int   sweep_cnt;
  exp_t q[$];

  adder_serial_nbit #(.N(8), .W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("carryout", 32'(carryout), 32'(e.c));
        chk("overflow", 32'(overflow), 32'(e.o));
      end
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic tc,
                       input logic [7:0] es, input logic ec,
                       input logic eo, input bit push);
    exp_t e;
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    if (push) begin
      e.s = es; e.c = ec; e.o = eo;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = 8'hA5; b = 8'h5A; sub = ~ts; cin = ~tc;
  endtask

  task automatic wait_done(input int lat, input bit run_chk,
                           input logic [7:0] hold);
    int n;
    n = 0;
    while (!done && n < 20) begin
      if (run_chk) begin
        chk("busy_run", 32'(busy), 32'(1));
        chk("sum_hold", 32'(sum), 32'(hold));
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    if (run_chk) chk("busy_done", 32'(busy), 32'(0));
  endtask

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int WW = 1 << g;
    localparam int DD = 4 / WW;
    logic       st, sb, ci, bs, dn, co, ov;
    logic [3:0] xa, xb, sm;
    logic [5:0] sq[$];

    adder_serial_nbit #(.N(4), .W(WW)) u (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (st),
      .sub      (sb),
      .cin      (ci),
      .a        (xa),
      .b        (xb),
      .busy     (bs),
      .done     (dn),
      .sum      (sm),
      .carryout (co),
      .overflow (ov)
    );

    always @(negedge clk) begin
      if (dn) begin
        if (sq.size() == 0) begin
          chk($sformatf("sweep_w%0d_unexpected", WW), 32'(dn), 32'(0));
        end else begin
          logic [5:0] e;
          e = sq.pop_front();
          chk($sformatf("sweep_w%0d", WW), 32'({co, sm, ov}), 32'(e));
        end
      end
    end

    initial begin
      st = 1'b0; sb = 1'b0; ci = 1'b0; xa = '0; xb = '0;
      wait (sweep_go);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < 2; c++) begin
          for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
              logic [3:0] bp;
              logic [4:0] full;
              logic       c0, eo;
              int         n;
              bp   = (m == 1) ? ~4'(ib) : 4'(ib);
              c0   = (m == 1) ? 1'b1 : 1'(c);
              full = 5'(ia) + 5'(bp) + 5'(c0);
              eo   = (ia[3] == bp[3]) && (full[3] != ia[3]);
              sq.push_back({full, eo});
              xa = 4'(ia); xb = 4'(ib);
              sb = 1'(m); ci = 1'(c); st = 1'b1;
              @(negedge clk);
              st = 1'b0;
              xa = ~xa; xb = ~xb;
              n = 0;
              while (!dn && n < 10) begin
                @(negedge clk);
                n++;
              end
              chk($sformatf("sweep_w%0d_lat", WW), 32'(n), 32'(DD));
            end
          end
        end
      end
      sweep_cnt++;
    end
  end

  initial begin
    int nd;
    int t;
    errors = 0; checks = 0; sweep_go = 1'b0; sweep_cnt = 0;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_carryout", 32'(carryout), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done(D, 1'b1, 8'h00);
    @(negedge clk);
    chk("idle_after_done", 32'(done), 32'(0));

    issue(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
    wait_done(D, 1'b0, 8'h00);
    issue(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    wait_done(D, 1'b0, 8'h00);
    issue(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    wait_done(D, 1'b0, 8'h00);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    wait_done(D, 1'b0, 8'h00);
    issue(8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
    wait_done(D, 1'b1, 8'h80);
    issue(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1);
    wait_done(D, 1'b0, 8'h00);
    @(negedge clk);

    // start during RUN must be ignored
    issue(8'h55, 8'h2A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(D - 2, 1'b0, 8'h00);
    // back-to-back: start during DONE
    issue(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1);
    wait_done(D, 1'b0, 8'h00);
    @(negedge clk);

    // reset in the 2nd RUN cycle
    issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_sum", 32'(sum), 32'(0));
    chk("arst_carryout", 32'(carryout), 32'(0));
    chk("arst_overflow", 32'(overflow), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 32'(0));
    issue(8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    wait_done(D, 1'b0, 8'h00);
    @(negedge clk);

    sweep_go = 1'b1;
    t = 0;
    while (sweep_cnt < 3 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_complete", 32'(sweep_cnt), 32'(3));
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_serial_nbit.md
Name: adder_serial_nbit

Overview:
- Digit-serial, multi-cycle N-bit adder/subtractor with a start/done handshake and add/sub mode select.
- Processes W bits per clock, so one operation takes N/W cycles; trades latency for area against the combinational N-bit adder.
- Reports carry-out and signed overflow.
- Sits in the arithmetic library as the area-optimised sibling of the combinational adder, for datapaths that can tolerate multi-cycle latency.

Parameters:
- N, 8, operand/result width in bits; must be >= 1.
- W, 2, digit width processed per cycle; 1 <= W <= N and N % W == 0, else elaboration $error.
- D = N/W is derived (localparam), not overridable; it is the number of RUN cycles.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled on a rising edge only while state is IDLE or DONE.
- sub  in  1  0 = add, 1 = subtract; latched with operands at accept.
- cin  in  1  carry-in for add mode; latched at accept; ignored in sub mode.
- a  in  N  operand A; latched at accept.
- b  in  N  operand B; latched at accept.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse, high exactly while state is DONE.
- sum  out  N  result of the last completed operation.
- carryout  out  1  carry out of bit N-1 for the last completed operation.
- overflow  out  1  signed (two's complement) overflow for the last completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, carryout=0, overflow=0.
  - Internal operand, carry and digit-counter registers are cleared.
- Effective operands:
  - Add: B' = b, c0 = cin.
  - Sub: B' = ~b, c0 = 1, so the operation is A + ~B + 1.
  - In sub mode, carryout=1 means no borrow (A >= B unsigned).
- States:
  - IDLE: start=1 -> latch a, B', c0; cnt=0; go to RUN. start=0 -> stay.
  - RUN: each edge adds digit cnt (bits cnt*W+W-1 : cnt*W) of A and B' plus the running carry. The digit sum goes into the result shift register; the carry is updated; cnt increments.
    - On the edge processing digit D-1: register sum, carryout and overflow; go to DONE.
    - start is ignored throughout RUN.
  - DONE: done=1 for this one cycle.
    - start=1 -> accept new operands, go to RUN (back-to-back, no bubble).
    - start=0 -> go to IDLE.
- Latency: if start is accepted at edge 0, RUN edges are 1..D and done is high between edges D and D+1. Throughput is one operation per D+1 cycles.
- Output updates:
  - sum/carryout/overflow change only on the final RUN edge; they hold their value in IDLE, RUN and DONE until the next completion.
  - Intermediate digits are never visible on sum.
- Overflow = (A[N-1] == B'[N-1]) && (sum[N-1] != A[N-1]).
- Width rules: all internal arithmetic uses W+1 bits per digit. cnt width is max(1, $clog2(D)). When D=1, RUN lasts exactly one edge.
- Input changes on a/b/sub/cin after accept have no effect on the operation in flight.
- Reset mid-operation: RUN is aborted immediately, every output returns to its reset value, and no done pulse is produced.

Test Plan:
- N=8, W=2; add a=8'hFF, b=8'h01, cin=0; start at edge 0 -> busy high for edges 1..4, done pulse after edge 4, sum=8'h00, carryout=1, overflow=0.
- N=8, W=2; sub a=8'h05, b=8'h07 -> sum=8'hFE, carryout=0, overflow=0; then sub a=8'h07, b=8'h05 -> sum=8'h02, carryout=1.
- N=8, W=2; add a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, overflow=1. Add a=8'h80, b=8'h80 -> sum=8'h00, carryout=1, overflow=1. Add a=8'h10, b=8'h20, cin=1 -> sum=8'h31.
- Pulse start with new operands while busy=1 -> ignored, first result intact. Assert start during the DONE cycle with a=8'h03, b=8'h04 -> RUN re-entered next edge, next done exactly D+1 cycles after the previous one, sum=8'h07.
- Drop rst_n during the 2nd RUN cycle -> busy, done, sum, carryout and overflow go to 0 asynchronously; no done pulse follows; a subsequent operation completes correctly.
- Exhaustive sweep: N=4 with each of W=1, 2, 4, both modes, cin in {0,1}, all a/b pairs -> {carryout, sum} matches the reference model a + B' + c0 and overflow matches the formula; for W=4 done appears 1 cycle after accept.
